// File: rtl/cache_pkg.sv
// Shared layout and state encoding for the 2-way write-back cache controller.
// Entry layout: {valid, dirty, tag, data}.
package cache_pkg;

  localparam int ENTRY_W = 12;
  localparam int VALID_B = 11;
  localparam int DIRTY_B = 10;
  localparam int TAG_HI  = 9;
  localparam int TAG_LO  = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COMPARE   = 3'd1;
  localparam logic [2:0] ST_WB        = 3'd2;
  localparam logic [2:0] ST_FILL_REQ  = 3'd3;
  localparam logic [2:0] ST_FILL_WAIT = 3'd4;
  localparam logic [2:0] ST_FILL      = 3'd5;
  localparam logic [2:0] ST_RESP      = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    COMPARE   = ST_COMPARE,
    WB        = ST_WB,
    FILL_REQ  = ST_FILL_REQ,
    FILL_WAIT = ST_FILL_WAIT,
    FILL      = ST_FILL,
    RESP      = ST_RESP
  } state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(
    input logic                     dirty,
    input logic [TAG_HI-TAG_LO:0]   tag,
    input logic [DATA_HI-DATA_LO:0] data
  );
    return {1'b1, dirty, tag, data};
  endfunction

endpackage

// File: rtl/cache_set_store.sv
// Tag/data/state storage for both ways of every set plus one LRU bit per set.
// Both ways read combinationally at the current index; one way written per cycle.
module cache_set_store
  import cache_pkg::*;
#(
  parameter int INDEX_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  output logic [ENTRY_W-1:0] entry0,
  output logic [ENTRY_W-1:0] entry1,
  output logic               lru,
  input  logic               wr_en,
  input  logic               wr_way,
  input  logic [ENTRY_W-1:0] wr_entry,
  input  logic               lru_we,
  input  logic               lru_val
);

  localparam int SETS = 1 << INDEX_W;

  logic [1:0][SETS-1:0][ENTRY_W-1:0] ways;
  logic [SETS-1:0]                   lru_bits;

  assign entry0 = ways[0][index];
  assign entry1 = ways[1][index];
  assign lru    = lru_bits[index];

  always_ff @(posedge clock) begin
    if (reset) begin
      ways     <= '0;
      lru_bits <= '0;
    end else begin
      if (wr_en)  ways[wr_way][index] <= wr_entry;
      if (lru_we) lru_bits[index]     <= lru_val;
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// 2-way set-associative, write-back/write-allocate cache controller in front of a
// 1-cycle-latency RAM. Misses refill and then re-run the lookup, so writes merge on the hit path.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INDEX_W = 3,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int              TAG_W   = ADDR_W - INDEX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state;
  logic                op_we;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_wdata;
  logic                first_pass;
  logic                victim_way;

  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [ENTRY_W-1:0]  entry0, entry1, miss_entry, wr_entry;
  logic [DATA_W-1:0]   hit_data;
  logic                lru, hit0, hit1, hit, hit_way, miss_way;
  logic                wr_en, wr_way, lru_we;

  assign index = op_addr[INDEX_W-1:0];
  assign tag   = op_addr[ADDR_W-1:INDEX_W];

  cache_set_store #(.INDEX_W(INDEX_W)) u_store (
    .clock    (clock),
    .reset    (reset),
    .index    (index),
    .entry0   (entry0),
    .entry1   (entry1),
    .lru      (lru),
    .wr_en    (wr_en),
    .wr_way   (wr_way),
    .wr_entry (wr_entry),
    .lru_we   (lru_we),
    .lru_val  (~hit_way)
  );

  // Lookup and victim choice; way0 takes priority on a (never expected) double match.
  always_comb begin
    hit0     = entry0[VALID_B] && (entry0[TAG_HI:TAG_LO] == tag);
    hit1     = entry1[VALID_B] && (entry1[TAG_HI:TAG_LO] == tag);
    hit      = hit0 || hit1;
    hit_way  = ~hit0;
    hit_data = hit_way ? entry1[DATA_HI:DATA_LO] : entry0[DATA_HI:DATA_LO];
    if (!entry0[VALID_B])      miss_way = 1'b0;
    else if (!entry1[VALID_B]) miss_way = 1'b1;
    else                       miss_way = lru;
    miss_entry = miss_way ? entry1 : entry0;
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_way   = hit_way;
    wr_entry = make_entry(1'b1, tag, op_wdata);
    lru_we   = 1'b0;
    if (state == COMPARE && hit) begin
      wr_en  = op_we;
      lru_we = 1'b1;
    end
    if (state == FILL) begin
      wr_en    = 1'b1;
      wr_way   = victim_way;
      wr_entry = make_entry(1'b0, tag, mem_rdata);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      op_we      <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      first_pass <= 1'b0;
      victim_way <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_hit    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_we      <= req_we;
            op_addr    <= req_addr;
            op_wdata   <= req_wdata;
            first_pass <= 1'b1;
            req_ready  <= 1'b0;
            state      <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            rsp_data  <= op_we ? op_wdata : hit_data;
            rsp_hit   <= first_pass;
            rsp_valid <= 1'b1;
            if (first_pass && hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;
            state     <= RESP;
          end else begin
            if (first_pass && miss_count != CNT_MAX) miss_count <= miss_count + 1'b1;
            first_pass <= 1'b0;
            victim_way <= miss_way;
            if (miss_entry[VALID_B] && miss_entry[DIRTY_B]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {miss_entry[TAG_HI:TAG_LO], index};
              mem_wdata <= miss_entry[DATA_HI:DATA_LO];
              state     <= WB;
            end else begin
              mem_addr <= op_addr;
              state    <= FILL_REQ;
            end
          end
        end
        WB: begin
          mem_we   <= 1'b0;
          mem_addr <= op_addr;
          state    <= FILL_REQ;
        end
        FILL_REQ:  state <= FILL_WAIT;
        FILL_WAIT: state <= FILL;
        FILL:      state <= COMPARE;
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default:   state <= IDLE;
      endcase
    end
  end

endmodule
